line_scheduler: RTL and testbench

Frame-level command scheduler for the line-drawing engine. It buffers line segments from the geometry/projection stage in an internal FIFO and waits for vertical sync. It then sequences the engine through one buffer clear followed by every queued line of that frame, one at a time. It sits between the geometry stage and the drawing engine.

---
 rtl/line_scheduler.sv | 254 +++++++++++++++++++++++++
 tb/tb_line_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_scheduler.sv
// line_scheduler: frame-level command scheduler for the line-drawing engine.
// Lines from the geometry stage are queued in a FIFO. On vsync, and only when
// a complete frame is queued and the engine is idle, the engine receives one
// buffer clear and then every in-range line of that frame, one at a time.
// Optional build macro LINE_SCHED_STATS_EN adds the o_lines_drawn and
// o_frames_missed statistics outputs.
module line_scheduler #(
  parameter int P_X_COORD_W       = 11,
  parameter int P_Y_COORD_W       = 11,
  parameter int P_SCREEN_W        = 640,
  parameter int P_SCREEN_H        = 480,
  parameter int P_LOG2_FIFO_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_line_valid,
  output logic                         o_line_ready,
  input  logic [P_X_COORD_W-1:0]       i_x0,
  input  logic [P_X_COORD_W-1:0]       i_x1,
  input  logic [P_Y_COORD_W-1:0]       i_y0,
  input  logic [P_Y_COORD_W-1:0]       i_y1,
  input  logic                         i_line_last,
  input  logic                         i_vsync,
  input  logic                         i_engine_idle,
  output logic                         o_engine_start,
  output logic                         o_engine_clear,
  output logic [P_X_COORD_W-1:0]       o_x0,
  output logic [P_X_COORD_W-1:0]       o_x1,
  output logic [P_Y_COORD_W-1:0]       o_y0,
  output logic [P_Y_COORD_W-1:0]       o_y1,
  output logic                         o_frame_done,
  output logic                         o_busy,
  output logic [P_LOG2_FIFO_DEPTH:0]   o_fifo_count
`ifdef LINE_SCHED_STATS_EN
  ,
  output logic [15:0]                  o_lines_drawn,
  output logic [15:0]                  o_frames_missed
`endif
);

  localparam int DEPTH   = 2 ** P_LOG2_FIFO_DEPTH;
  localparam int ENTRY_W = 2 * P_X_COORD_W + 2 * P_Y_COORD_W + 2;
  localparam logic [P_LOG2_FIFO_DEPTH:0] DEPTH_C  = (P_LOG2_FIFO_DEPTH+1)'(DEPTH);
  localparam logic [P_X_COORD_W-1:0]     X_LIMIT  = P_X_COORD_W'(P_SCREEN_W);
  localparam logic [P_Y_COORD_W-1:0]     Y_LIMIT  = P_Y_COORD_W'(P_SCREEN_H);

  // Entry layout (MSB..LSB): x0, x1, y0, y1, last, skip
  localparam int SKIP_B = 0;
  localparam int LAST_B = 1;
  localparam int Y1_LSB = 2;
  localparam int Y0_LSB = Y1_LSB + P_Y_COORD_W;
  localparam int X1_LSB = Y0_LSB + P_Y_COORD_W;
  localparam int X0_LSB = X1_LSB + P_X_COORD_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_START,
    S_CLR_WAIT,
    S_POP,
    S_LN_START,
    S_LN_WAIT,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [ENTRY_W-1:0]             fifo_mem [DEPTH];
  logic [P_LOG2_FIFO_DEPTH-1:0]   wr_ptr_reg;
  logic [P_LOG2_FIFO_DEPTH-1:0]   rd_ptr_reg;
  logic [P_LOG2_FIFO_DEPTH:0]     count_reg;
  logic [P_LOG2_FIFO_DEPTH:0]     pending_reg;
  logic                           seen_low_reg;
  logic                           line_last_reg;
  logic [P_X_COORD_W-1:0]         x0_reg, x1_reg;
  logic [P_Y_COORD_W-1:0]         y0_reg, y1_reg;

  logic                           push;
  logic                           pop;
  logic                           push_skip;
  logic                           done_enter;
  logic [ENTRY_W-1:0]             head;
  logic                           head_skip;
  logic                           head_last;

  assign o_line_ready = (count_reg < DEPTH_C);
  assign push         = i_line_valid && o_line_ready;
  // A pop only happens with data present; a queued frame always holds its own
  // last entry, so the empty guard is purely defensive.
  assign pop          = (state_reg == S_POP) && (count_reg != '0);

  // Out-of-range lines are kept so a skipped last still closes its frame.
  assign push_skip = (i_x0 >= X_LIMIT) || (i_x1 >= X_LIMIT) ||
                     (i_y0 >= Y_LIMIT) || (i_y1 >= Y_LIMIT);

  // The POP decision needs the head flags in the same cycle, so the head is
  // read directly from the storage array.
  assign head      = fifo_mem[rd_ptr_reg];
  assign head_skip = head[SKIP_B];
  assign head_last = head[LAST_B];

  assign done_enter = (state_next == S_DONE) && (state_reg != S_DONE);

  // FIFO storage write; contents need no reset because pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {i_x0, i_x1, i_y0, i_y1, i_line_last, push_skip};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the depth.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Number of complete frames sitting in the FIFO.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pending_reg <= '0;
    end else begin
      case ({push && i_line_last, done_enter})
        2'b10:   pending_reg <= pending_reg + 1'b1;
        2'b01:   pending_reg <= pending_reg - 1'b1;
        default: pending_reg <= pending_reg;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic and state-decoded command outputs.
  always_comb begin
    state_next     = state_reg;
    o_engine_start = 1'b0;
    o_engine_clear = 1'b0;
    o_frame_done   = 1'b0;
    o_busy         = 1'b1;
    case (state_reg)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_vsync && (pending_reg != '0) && i_engine_idle) state_next = S_CLR_START;
      end
      S_CLR_START: begin
        o_engine_start = 1'b1;
        o_engine_clear = 1'b1;
        state_next     = S_CLR_WAIT;
      end
      S_CLR_WAIT: begin
        if (seen_low_reg && i_engine_idle) state_next = S_POP;
      end
      S_POP: begin
        if (count_reg != '0) begin
          if (!head_skip)     state_next = S_LN_START;
          else if (head_last) state_next = S_DONE;
          else                state_next = S_POP;
        end
      end
      S_LN_START: begin
        o_engine_start = 1'b1;
        state_next     = S_LN_WAIT;
      end
      S_LN_WAIT: begin
        if (seen_low_reg && i_engine_idle) state_next = line_last_reg ? S_DONE : S_POP;
      end
      S_DONE: begin
        o_frame_done = 1'b1;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Engine acknowledge: latch a low idle level so a fast engine is not missed.
  always_ff @(posedge i_clk) begin
    if (i_reset || (state_reg == S_CLR_START) || (state_reg == S_LN_START)) begin
      seen_low_reg <= 1'b0;
    end else if (((state_reg == S_CLR_WAIT) || (state_reg == S_LN_WAIT)) && !i_engine_idle) begin
      seen_low_reg <= 1'b1;
    end
  end

  // Line coordinates to the engine, captured on every pop and held until the next.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      x0_reg        <= '0;
      x1_reg        <= '0;
      y0_reg        <= '0;
      y1_reg        <= '0;
      line_last_reg <= 1'b0;
    end else if (pop) begin
      x0_reg        <= head[X0_LSB +: P_X_COORD_W];
      x1_reg        <= head[X1_LSB +: P_X_COORD_W];
      y0_reg        <= head[Y0_LSB +: P_Y_COORD_W];
      y1_reg        <= head[Y1_LSB +: P_Y_COORD_W];
      line_last_reg <= head_last;
    end
  end

  assign o_x0         = x0_reg;
  assign o_x1         = x1_reg;
  assign o_y0         = y0_reg;
  assign o_y1         = y1_reg;
  assign o_fifo_count = count_reg;

`ifdef LINE_SCHED_STATS_EN
  logic [15:0] lines_drawn_reg;
  logic [15:0] frames_missed_reg;
  logic        vsync_missed;

  // A vsync is lost when the sequencer is mid-frame, or when a frame is
  // queued but the engine is not idle.
  assign vsync_missed = i_vsync &&
                        ((state_reg != S_IDLE) || ((pending_reg != '0) && !i_engine_idle));

  // Line commands issued in the current frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      lines_drawn_reg <= '0;
    end else if ((state_reg == S_IDLE) && (state_next == S_CLR_START)) begin
      lines_drawn_reg <= '0;
    end else if (state_reg == S_LN_START) begin
      lines_drawn_reg <= lines_drawn_reg + 1'b1;
    end
  end

  // Saturating count of missed frame starts.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      frames_missed_reg <= '0;
    end else if (vsync_missed && (frames_missed_reg != 16'hFFFF)) begin
      frames_missed_reg <= frames_missed_reg + 1'b1;
    end
  end

  assign o_lines_drawn   = lines_drawn_reg;
  assign o_frames_missed = frames_missed_reg;
`endif

endmodule

// File: tb/tb_line_scheduler.sv
// Testbench for line_scheduler: directed scenarios plus randomized traffic,
// checked against a frame-level reference model (queue of pushed lines,
// queue of expected engine commands). Stats checks follow LINE_SCHED_STATS_EN.
module tb_line_scheduler;

  localparam int XW    = 11;
  localparam int YW    = 11;
  localparam int SW    = 640;
  localparam int SH    = 480;
  localparam int LOG2D = 4;
  localparam int DEPTH = 16;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_line_valid;
  logic             o_line_ready;
  logic [XW-1:0]    i_x0, i_x1;
  logic [YW-1:0]    i_y0, i_y1;
  logic             i_line_last;
  logic             i_vsync;
  logic             i_engine_idle;
  logic             o_engine_start;
  logic             o_engine_clear;
  logic [XW-1:0]    o_x0, o_x1;
  logic [YW-1:0]    o_y0, o_y1;
  logic             o_frame_done;
  logic             o_busy;
  logic [LOG2D:0]   o_fifo_count;
`ifdef LINE_SCHED_STATS_EN
  logic [15:0]      o_lines_drawn;
  logic [15:0]      o_frames_missed;
`endif

  always #5 i_clk = ~i_clk;

  line_scheduler #(
    .P_X_COORD_W(XW), .P_Y_COORD_W(YW), .P_SCREEN_W(SW), .P_SCREEN_H(SH),
    .P_LOG2_FIFO_DEPTH(LOG2D)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_line_valid(i_line_valid), .o_line_ready(o_line_ready),
    .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0), .i_y1(i_y1),
    .i_line_last(i_line_last), .i_vsync(i_vsync), .i_engine_idle(i_engine_idle),
    .o_engine_start(o_engine_start), .o_engine_clear(o_engine_clear),
    .o_x0(o_x0), .o_x1(o_x1), .o_y0(o_y0), .o_y1(o_y1),
    .o_frame_done(o_frame_done), .o_busy(o_busy), .o_fifo_count(o_fifo_count)
`ifdef LINE_SCHED_STATS_EN
    , .o_lines_drawn(o_lines_drawn), .o_frames_missed(o_frames_missed)
`endif
  );

  typedef struct { int x0; int x1; int y0; int y1; bit last; } line_t;
  typedef struct { bit clr; int x0; int x1; int y0; int y1; } cmd_t;

  line_t stim_q[$];    // lines waiting to be offered
  line_t model_q[$];   // lines accepted and not yet claimed by a frame
  cmd_t  exp_cmd[$];   // engine commands still expected

  int checks = 0;
  int errors = 0;

  bit active;            // model believes a frame is in progress
  bit release_pending;   // frame_done seen; sequencer idle from next cycle
  bit vsync_req;
  bit eng_hold;
  bit eng_idle;
  int eng_delay, eng_busy;
  int exp_done;
  int exp_missed;
  int exp_frame_lines;
  int frame_lines;       // line starts observed in the current frame

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit is_skip(line_t l);
    return (l.x0 >= SW) || (l.x1 >= SW) || (l.y0 >= SH) || (l.y1 >= SH);
  endfunction

  function automatic int pending_frames();
    int n = 0;
    foreach (model_q[i]) if (model_q[i].last) n++;
    return n;
  endfunction

  function automatic line_t mk_line(int x0, int x1, int y0, int y1, bit last);
    line_t l;
    l.x0 = x0; l.x1 = x1; l.y0 = y0; l.y1 = y1; l.last = last;
    return l;
  endfunction

  function automatic line_t rand_line(bit last);
    return mk_line(int'($urandom_range(0, 699)), int'($urandom_range(0, 699)),
                   int'($urandom_range(0, 519)), int'($urandom_range(0, 519)), last);
  endfunction

  // One clock of the bench: observe at the falling edge, then drive.
  task automatic tick();
    cmd_t  c;
    line_t l;
    @(negedge i_clk);
    if (release_pending) begin
      active = 1'b0;
      release_pending = 1'b0;
    end

    if (o_engine_start) begin
      if (exp_cmd.size() == 0) begin
        check("unexpected_start", 1, 0);
      end else begin
        c = exp_cmd.pop_front();
        check("cmd_clear", o_engine_clear, c.clr);
        if (c.clr) begin
          frame_lines = 0;
        end else begin
          frame_lines++;
          check("line_x0", o_x0, c.x0);
          check("line_x1", o_x1, c.x1);
          check("line_y0", o_y0, c.y0);
          check("line_y1", o_y1, c.y1);
        end
      end
    end

    if (o_frame_done) begin
      if (exp_done == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_done--;
        check("cmds_left_at_done", exp_cmd.size(), 0);
`ifdef LINE_SCHED_STATS_EN
        check("lines_drawn", o_lines_drawn, exp_frame_lines);
`endif
        release_pending = 1'b1;
      end
    end

    if (!active) begin
      check("idle_busy", o_busy, 0);
      check("idle_count", o_fifo_count, model_q.size());
      check("idle_ready", o_line_ready, model_q.size() < DEPTH);
    end

    // Engine model: goes busy one cycle after a start, stays busy 5 cycles.
    if (o_engine_start) begin
      eng_delay = 1;
      eng_busy  = 5;
    end else if (eng_delay > 0) begin
      eng_delay--;
      if (eng_delay == 0) eng_idle = 1'b0;
    end else if (eng_busy > 0) begin
      eng_busy--;
      if (eng_busy == 0) eng_idle = 1'b1;
    end
    i_engine_idle = eng_idle && !eng_hold;

    // Frame start: launches only when idle with a whole frame queued.
    i_vsync = 1'b0;
    if (vsync_req) begin
      vsync_req = 1'b0;
      i_vsync   = 1'b1;
      if (!active && (pending_frames() > 0) && i_engine_idle) begin
        active = 1'b1;
        exp_done++;
        frame_lines = 0;
        exp_frame_lines = 0;
        c.clr = 1'b1; c.x0 = 0; c.x1 = 0; c.y0 = 0; c.y1 = 0;
        exp_cmd.push_back(c);
        forever begin
          l = model_q.pop_front();
          if (!is_skip(l)) begin
            c.clr = 1'b0; c.x0 = l.x0; c.x1 = l.x1; c.y0 = l.y0; c.y1 = l.y1;
            exp_cmd.push_back(c);
            exp_frame_lines++;
          end
          if (l.last) break;
        end
      end else if (active || (pending_frames() > 0)) begin
        exp_missed++;
      end
    end

    // Line offer: transfers when the scheduler shows ready.
    i_line_valid = 1'b0;
    i_line_last  = 1'b0;
    if (stim_q.size() > 0) begin
      l = stim_q[0];
      i_x0 = XW'(l.x0); i_x1 = XW'(l.x1);
      i_y0 = YW'(l.y0); i_y1 = YW'(l.y1);
      i_line_last  = l.last;
      i_line_valid = 1'b1;
      if (o_line_ready) begin
        model_q.push_back(l);
        void'(stim_q.pop_front());
      end
    end
  endtask

  task automatic wait_frame_end(int budget);
    int n = 0;
    while ((active || release_pending) && n < budget) begin
      tick();
      n++;
    end
    if (active) check("frame_timeout", 1, 0);
  endtask

  task automatic wait_line_started(int budget);
    int n = 0;
    while (frame_lines < 1 && n < budget) begin
      tick();
      n++;
    end
    if (frame_lines < 1) check("line_start_timeout", 1, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", o_line_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_start", o_engine_start, 0);
    check("rst_clear", o_engine_clear, 0);
    check("rst_done", o_frame_done, 0);
    check("rst_count", o_fifo_count, 0);
    check("rst_x0", o_x0, 0);
    check("rst_x1", o_x1, 0);
    check("rst_y0", o_y0, 0);
    check("rst_y1", o_y1, 0);
`ifdef LINE_SCHED_STATS_EN
    check("rst_lines_drawn", o_lines_drawn, 0);
    check("rst_frames_missed", o_frames_missed, 0);
`endif
  endtask

  // Synchronous reset applied mid-operation; the model is flushed with the DUT.
  task automatic apply_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    i_line_valid = 1'b0;
    i_vsync = 1'b0;
    stim_q.delete();
    model_q.delete();
    exp_cmd.delete();
    active = 1'b0; release_pending = 1'b0; vsync_req = 1'b0;
    exp_done = 0; exp_missed = 0; frame_lines = 0;
    eng_delay = 0; eng_busy = 0; eng_idle = 1'b1; eng_hold = 1'b0;
    i_engine_idle = 1'b1;
    @(negedge i_clk);
    check_reset_outputs();
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    i_line_valid = 1'b0; i_line_last = 1'b0; i_vsync = 1'b0;
    i_x0 = '0; i_x1 = '0; i_y0 = '0; i_y1 = '0;
    eng_idle = 1'b1; eng_hold = 1'b0; i_engine_idle = 1'b1;
    eng_delay = 0; eng_busy = 0;
    active = 1'b0; release_pending = 1'b0; vsync_req = 1'b0;
    exp_done = 0; exp_missed = 0; frame_lines = 0; exp_frame_lines = 0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_outputs();
    i_reset = 1'b0;

    // vsync with nothing queued: no command, sequencer stays idle
    repeat (2) tick();
    vsync_req = 1'b1;
    repeat (10) tick();

    // Three lines, last on the third
    stim_q.push_back(mk_line(10, 20, 30, 40, 1'b0));
    stim_q.push_back(mk_line(100, 639, 0, 479, 1'b0));
    stim_q.push_back(mk_line(5, 6, 7, 8, 1'b1));
    repeat (5) tick();
    vsync_req = 1'b1;
    tick();
    wait_frame_end(300);
    tick();
    check("three_lines_count", o_fifo_count, 0);

    // Fill the FIFO: 16 accepted, the 17th held off until a pop
    for (int i = 0; i < 17; i++) stim_q.push_back(mk_line(i, i + 1, i + 2, i + 3, (i >= 15)));
    repeat (20) tick();
    check("full_ready", o_line_ready, 0);
    check("full_count", o_fifo_count, DEPTH);
    check("full_held_offer", stim_q.size(), 1);
    vsync_req = 1'b1;
    tick();
    wait_frame_end(600);
    tick();
    check("after_full_count", o_fifo_count, 1);
    vsync_req = 1'b1;
    tick();
    wait_frame_end(300);

    // Out-of-range last line: only the valid line is issued
    stim_q.push_back(mk_line(1, 2, 3, 4, 1'b0));
    stim_q.push_back(mk_line(700, 10, 5, 5, 1'b1));
    repeat (4) tick();
    vsync_req = 1'b1;
    tick();
    wait_frame_end(300);
    check("skip_lines_issued", frame_lines, 1);

    // Second vsync while waiting on a line is ignored
    stim_q.push_back(mk_line(50, 60, 70, 80, 1'b0));
    stim_q.push_back(mk_line(90, 91, 92, 93, 1'b1));
    repeat (4) tick();
    vsync_req = 1'b1;
    tick();
    wait_line_started(100);
    repeat (2) tick();
    vsync_req = 1'b1;
    tick();
    wait_frame_end(300);
`ifdef LINE_SCHED_STATS_EN
    check("frames_missed_lnwait", o_frames_missed, exp_missed);
`endif

    // Reset while waiting on a line: abort, flush, no further commands
    stim_q.push_back(mk_line(11, 12, 13, 14, 1'b0));
    stim_q.push_back(mk_line(15, 16, 17, 18, 1'b0));
    stim_q.push_back(mk_line(19, 20, 21, 22, 1'b1));
    repeat (5) tick();
    vsync_req = 1'b1;
    tick();
    wait_line_started(100);
    repeat (2) tick();
    apply_reset();
    repeat (5) tick();
    vsync_req = 1'b1;
    repeat (25) tick();

    // Randomized traffic: lines, vsyncs and engine stalls
    for (int it = 0; it < 1500; it++) begin
      if (stim_q.size() < 3 && $urandom_range(0, 2) == 0)
        stim_q.push_back(rand_line($urandom_range(0, 3) == 0));
      if (!active && $urandom_range(0, 19) == 0) eng_hold = !eng_hold;
      if ($urandom_range(0, 14) == 0) vsync_req = 1'b1;
      tick();
    end

    // Drain: close the last frame and run frames until empty
    eng_hold = 1'b0;
    stim_q.push_back(rand_line(1'b1));
    wait_frame_end(400);
    for (int k = 0; k < 40; k++) begin
      if (model_q.size() == 0 && stim_q.size() == 0) break;
      vsync_req = 1'b1;
      tick();
      wait_frame_end(400);
    end
    repeat (3) tick();
    check("drain_count", o_fifo_count, 0);
    check("drain_exp_done", exp_done, 0);
`ifdef LINE_SCHED_STATS_EN
    check("frames_missed_final", o_frames_missed, exp_missed);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
